// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage: memory op encoding, the EX/MEM
// and MEM/WB bundles, the stage FSM states and op classification functions.
package mem_stage_pkg;

    localparam int MEM_XLEN       = 32;
    localparam int MEM_REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_t;

    typedef struct packed {
        logic [MEM_REG_ADDR_W-1:0] rd_addr;
        logic [MEM_XLEN-1:0]       rd_data;
        mem_op_t                   mem_op;
        logic [MEM_XLEN-1:0]       mem_data;
    } mem_params_t;

    typedef struct packed {
        logic [MEM_REG_ADDR_W-1:0] rd_addr;
        logic [MEM_XLEN-1:0]       rd_data;
    } wb_params_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_t;

    function automatic logic mem_is_load(input mem_op_t op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic mem_is_store(input mem_op_t op);
        case (op)
            MEM_OP_SB, MEM_OP_SH, MEM_OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic mem_is_misaligned(input mem_op_t op, input logic [1:0] offs);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return offs[0];
            MEM_OP_LW, MEM_OP_SW:             return (offs != 2'b00);
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword from a bus
// word and sign- or zero-extends it. Shared with the data cache.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  mem_op_t         mem_op,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the byte and halfword lanes addressed by the offset
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (offset)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane according to the load type
    always_comb begin
        result = word;
        case (mem_op)
            MEM_OP_LB:  result = {{(XLEN-8){byte_s[7]}}, byte_s};
            MEM_OP_LBU: result = {{(XLEN-8){1'b0}}, byte_s};
            MEM_OP_LH:  result = {{(XLEN-16){half_s[15]}}, half_s};
            MEM_OP_LHU: result = {{(XLEN-16){1'b0}}, half_s};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus, stalls the
// front of the pipe while an access is outstanding and registers the
// writeback bundle for WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  mem_params_t       mem_params_in,
    output logic              stall,
    output wb_params_t        wb_params_out,
    output logic              exc_misaligned,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata
);

    mem_state_t            state_r;
    mem_state_t            state_nxt_s;
    mem_op_t               op_s;
    logic [XLEN-1:0]       addr_s;
    logic                  misalign_s;
    logic                  issue_s;
    logic                  stall_s;
    logic [3:0]            be_s;
    logic [XLEN-1:0]       wdata_s;
    logic [XLEN-1:0]       load_result_s;
    wb_params_t            wb_nxt_s;
    logic                  exc_nxt_s;

    // Access context held from issue until the ack arrives
    mem_op_t               op_r;
    logic [1:0]            offset_r;
    logic [REG_ADDR_W-1:0] rd_addr_r;

    logic                  dmem_req_r;
    logic                  dmem_we_r;
    logic [XLEN-1:0]       dmem_addr_r;
    logic [3:0]            dmem_be_r;
    logic [XLEN-1:0]       dmem_wdata_r;
    wb_params_t            wb_r;
    logic                  exc_r;

    assign op_s       = mem_params_in.mem_op;
    assign addr_s     = mem_params_in.rd_data;
    assign misalign_s = mem_is_misaligned(op_s, addr_s[1:0]);
    assign issue_s    = (state_r == ST_IDLE) && (mem_is_load(op_s) || mem_is_store(op_s)) && !misalign_s;

    assign stall          = stall_s;
    assign dmem_req       = dmem_req_r;
    assign dmem_we        = dmem_we_r;
    assign dmem_addr      = dmem_addr_r;
    assign dmem_be        = dmem_be_r;
    assign dmem_wdata     = dmem_wdata_r;
    assign wb_params_out  = wb_r;
    assign exc_misaligned = exc_r;

    load_align #(.XLEN(XLEN)) u_load_align (
        .word   (dmem_rdata),
        .offset (offset_r),
        .mem_op (op_r),
        .result (load_result_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and stall: stall on issue and for every REQ cycle without ack
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    stall_s     = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    stall_s     = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                stall_s     = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming op
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = mem_params_in.mem_data;
        case (op_s)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: be_s = 4'b0001 << addr_s[1:0];
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: be_s = addr_s[1] ? 4'b1100 : 4'b0011;
            MEM_OP_LW, MEM_OP_SW:             be_s = 4'b1111;
            default:                          be_s = 4'b0000;
        endcase
        case (op_s)
            MEM_OP_SB: wdata_s = {4{mem_params_in.mem_data[7:0]}};
            MEM_OP_SH: wdata_s = {2{mem_params_in.mem_data[15:0]}};
            default:   wdata_s = mem_params_in.mem_data;
        endcase
    end

    // Bus request registers: load on issue, hold through REQ, drop on ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= '0;
            dmem_be_r    <= 4'b0000;
            dmem_wdata_r <= '0;
            op_r         <= MEM_OP_NONE;
            offset_r     <= 2'b00;
            rd_addr_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= mem_is_store(op_s);
                        dmem_addr_r  <= {addr_s[XLEN-1:2], 2'b00};
                        dmem_be_r    <= be_s;
                        dmem_wdata_r <= wdata_s;
                        op_r         <= op_s;
                        offset_r     <= addr_s[1:0];
                        rd_addr_r    <= mem_params_in.rd_addr;
                    end else begin
                        dmem_req_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                    end else begin
                        dmem_req_r <= 1'b1;
                    end
                end
                default: begin
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    // Writeback and exception values: bubbles and stores never name a register
    always_comb begin
        wb_nxt_s  = '0;
        exc_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_s == MEM_OP_NONE) begin
                    wb_nxt_s.rd_addr = mem_params_in.rd_addr;
                    wb_nxt_s.rd_data = mem_params_in.rd_data;
                end else if (misalign_s) begin
                    exc_nxt_s = 1'b1;
                end else begin
                    wb_nxt_s = '0;
                end
            end
            ST_REQ: begin
                if (dmem_ack && mem_is_load(op_r)) begin
                    wb_nxt_s.rd_addr = rd_addr_r;
                    wb_nxt_s.rd_data = load_result_s;
                end else begin
                    wb_nxt_s = '0;
                end
            end
            default: begin
                wb_nxt_s  = '0;
                exc_nxt_s = 1'b0;
            end
        endcase
    end

    // MEM/WB register and misaligned-access pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_r  <= '0;
            exc_r <= 1'b0;
        end else begin
            wb_r  <= wb_nxt_s;
            exc_r <= exc_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expected values.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    mem_params_t mp;
    logic        stall;
    wb_params_t  wb;
    logic        exc;
    logic        req, we, ack;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_params_in  (mp),
        .stall          (stall),
        .wb_params_out  (wb),
        .exc_misaligned (exc),
        .dmem_req       (req),
        .dmem_we        (we),
        .dmem_addr      (addr),
        .dmem_be        (be),
        .dmem_wdata     (wdata),
        .dmem_ack       (ack),
        .dmem_rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input mem_op_t op, input logic [4:0] rd, input logic [31:0] d, input logic [31:0] md);
        mp.mem_op   = op;
        mp.rd_addr  = rd;
        mp.rd_data  = d;
        mp.mem_data = md;
    endtask

    // Runs one aligned access from IDLE with 'waits' ack-less REQ cycles.
    // Returns at the negedge after the ack edge, with EX/MEM reloaded by NONE.
    task automatic run_mem(input mem_op_t op, input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] md, input int waits, input logic [31:0] rd_word,
                           output int stall_cyc, output logic [31:0] o_addr, output logic [3:0] o_be,
                           output logic o_we, output logic [31:0] o_wdata, output logic o_stable);
        drive(op, rd, a, md);
        stall_cyc = 0;
        #1;
        if (stall) stall_cyc++;
        @(posedge clk);
        @(negedge clk);
        o_addr   = addr;
        o_be     = be;
        o_we     = we;
        o_wdata  = wdata;
        o_stable = req;
        for (int i = 0; i < waits; i++) begin
            if (stall) stall_cyc++;
            if (!req || addr !== o_addr || be !== o_be || wdata !== o_wdata || we !== o_we) o_stable = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        ack   = 1'b1;
        rdata = rd_word;
        #1;
        if (stall) stall_cyc++;
        if (!req || addr !== o_addr || be !== o_be || wdata !== o_wdata || we !== o_we) o_stable = 1'b0;
        @(posedge clk);
        #1;
        ack   = 1'b0;
        rdata = 32'h0000_0000;
        drive(MEM_OP_NONE, 5'd0, 32'h0000_0000, 32'h0000_0000);
        @(negedge clk);
    endtask

    int          sc;
    logic [31:0] oa, ow;
    logic [3:0]  ob;
    logic        owe, ost;

    initial begin
        rst_n = 1'b0;
        ack   = 1'b0;
        rdata = 32'h0000_0000;
        drive(MEM_OP_NONE, 5'd0, 32'h0000_0000, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rst_req", {63'd0, req}, 64'd0);
        chk_eq("rst_be_addr_wdata", {28'd0, be, addr}, 64'd0);
        chk_eq("rst_wdata_we", {31'd0, we, wdata}, 64'd0);
        chk_eq("rst_wb_exc", {26'd0, exc, wb}, 64'd0);
        rst_n = 1'b1;

        // Plain pass-through: one-cycle latency, no stall, no bus activity
        drive(MEM_OP_NONE, 5'd3, 32'h0000_1234, 32'h0000_0000);
        #1;
        chk_eq("none_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("none_wb", {27'd0, wb}, {27'd0, 5'd3, 32'h0000_1234});
        chk_eq("none_req", {63'd0, req}, 64'd0);

        // LW with two wait cycles
        run_mem(MEM_OP_LW, 32'h0000_0100, 5'd5, 32'h0, 2, 32'hDEAD_BEEF, sc, oa, ob, owe, ow, ost);
        chk_eq("lw_stall_cycles", 64'(sc), 64'd3);
        chk_eq("lw_addr", {32'd0, oa}, 64'h100);
        chk_eq("lw_be_we", {59'd0, owe, ob}, {59'd0, 1'b0, 4'b1111});
        chk_eq("lw_stable", {63'd0, ost}, 64'd1);
        chk_eq("lw_wb", {27'd0, wb}, {27'd0, 5'd5, 32'hDEAD_BEEF});
        chk_eq("lw_req_dropped", {63'd0, req}, 64'd0);

        // Byte loads from the top lane: signed and unsigned
        run_mem(MEM_OP_LB, 32'h0000_0103, 5'd7, 32'h0, 0, 32'h8012_3456, sc, oa, ob, owe, ow, ost);
        chk_eq("lb_addr_be", {28'd0, ob, oa}, {28'd0, 4'b1000, 32'h0000_0100});
        chk_eq("lb_wb", {27'd0, wb}, {27'd0, 5'd7, 32'hFFFF_FF80});
        run_mem(MEM_OP_LBU, 32'h0000_0103, 5'd8, 32'h0, 1, 32'h8012_3456, sc, oa, ob, owe, ow, ost);
        chk_eq("lbu_wb", {27'd0, wb}, {27'd0, 5'd8, 32'h0000_0080});

        // Halfword loads: upper lane signed, lower lane unsigned
        run_mem(MEM_OP_LH, 32'h0000_0042, 5'd10, 32'h0, 0, 32'h8001_7FFF, sc, oa, ob, owe, ow, ost);
        chk_eq("lh_be", {60'd0, ob}, {60'd0, 4'b1100});
        chk_eq("lh_wb", {27'd0, wb}, {27'd0, 5'd10, 32'hFFFF_8001});
        run_mem(MEM_OP_LHU, 32'h0000_0040, 5'd11, 32'h0, 0, 32'h8001_FFFE, sc, oa, ob, owe, ow, ost);
        chk_eq("lhu_be", {60'd0, ob}, {60'd0, 4'b0011});
        chk_eq("lhu_wb", {27'd0, wb}, {27'd0, 5'd11, 32'h0000_FFFE});

        // SH acked in the request cycle
        run_mem(MEM_OP_SH, 32'h0000_0102, 5'd9, 32'h0000_ABCD, 0, 32'h1111_1111, sc, oa, ob, owe, ow, ost);
        chk_eq("sh_stall_cycles", 64'(sc), 64'd1);
        chk_eq("sh_bus", {27'd0, owe, ob, ow}, {27'd0, 1'b1, 4'b1100, 32'hABCD_ABCD});
        chk_eq("sh_addr", {32'd0, oa}, 64'h100);
        chk_eq("sh_wb", {27'd0, wb}, 64'd0);

        // SB and SW lane handling
        run_mem(MEM_OP_SB, 32'h0000_0201, 5'd12, 32'h1234_565A, 1, 32'h0, sc, oa, ob, owe, ow, ost);
        chk_eq("sb_bus", {27'd0, owe, ob, ow}, {27'd0, 1'b1, 4'b0010, 32'h5A5A_5A5A});
        chk_eq("sb_stable", {63'd0, ost}, 64'd1);
        run_mem(MEM_OP_SW, 32'h0000_0300, 5'd13, 32'h1234_5678, 0, 32'h0, sc, oa, ob, owe, ow, ost);
        chk_eq("sw_bus", {27'd0, owe, ob, ow}, {27'd0, 1'b1, 4'b1111, 32'h1234_5678});
        chk_eq("sw_wb", {27'd0, wb}, 64'd0);

        // Misaligned LW: no request, one-cycle exception pulse, no register write
        drive(MEM_OP_LW, 5'd14, 32'h0000_0101, 32'h0);
        #1;
        chk_eq("mis_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("mis_req", {63'd0, req}, 64'd0);
        chk_eq("mis_exc", {63'd0, exc}, 64'd1);
        chk_eq("mis_wb_rd", {59'd0, wb.rd_addr}, 64'd0);
        drive(MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("mis_exc_pulse", {63'd0, exc}, 64'd0);

        // Ack while idle is ignored
        drive(MEM_OP_NONE, 5'd4, 32'h0000_0055, 32'h0);
        ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_eq("idle_ack_req", {63'd0, req}, 64'd0);
        chk_eq("idle_ack_wb", {27'd0, wb}, {27'd0, 5'd4, 32'h0000_0055});
        ack = 1'b0;

        // Reset in the middle of an outstanding load
        drive(MEM_OP_LW, 5'd6, 32'h0000_0400, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rstmid_req_before", {63'd0, req}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("rstmid_req_async", {63'd0, req}, 64'd0);
        drive(MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ack   = 1'b1;
        rdata = 32'hCAFE_F00D;
        #1;
        chk_eq("rstmid_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rstmid_wb", {27'd0, wb}, 64'd0);
        chk_eq("rstmid_req_after", {63'd0, req}, 64'd0);
        ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_eq("rstmid_wb_later", {27'd0, wb}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM-stage consumer of the EX/MEM register output.
- Decodes mem_params_t and runs loads and stores on the data-memory bus using a req/ack handshake.
- Stalls upstream stages while an access is outstanding.
- Aligns and extends load data, then registers the writeback bundle (wb_params_t) for the WB stage, so the MEM/WB boundary is internal to this block.

Parameters:
- XLEN, 32, data and address width
- REG_ADDR_W, 5, register index width (must match types package)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_params_in  in  mem_params_t  from EX/MEM: rd_addr, rd_data (ALU result = effective address for mem ops), mem_op, mem_data (store data)
- stall  out  1  hold EX/MEM and all earlier stages this cycle
- wb_params_out  out  wb_params_t  registered to WB: rd_addr, rd_data
- exc_misaligned  out  1  registered one-cycle pulse on a misaligned access
- dmem_req  out  1  bus request (registered)
- dmem_we  out  1  1 = store (registered)
- dmem_addr  out  XLEN  word-aligned address, bits [1:0] = 0 (registered)
- dmem_be  out  4  byte enables (registered)
- dmem_wdata  out  XLEN  lane-replicated store data (registered)
- dmem_ack  in  1  request accepted; load data valid this cycle
- dmem_rdata  in  XLEN  load word

Behaviour:
- Reset (async, rst_n low): state IDLE.
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, wb_params_out.rd_addr=0, wb_params_out.rd_data=0, exc_misaligned=0.
- Asserting reset mid-access drops dmem_req immediately and abandons the access. No completion and no writeback follow.
- mem_op values: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0.
- FSM has two states, IDLE and REQ.
- IDLE, mem_op=NONE:
  - stall=0.
  - Next cycle, wb_params_out = {rd_addr, rd_data}, giving 1-cycle latency.
- IDLE, misaligned load or store:
  - stall=0, no bus activity.
  - Next cycle, exc_misaligned=1 and wb_params_out.rd_addr=0.
- IDLE, aligned load or store:
  - stall=1 combinationally.
  - Register dmem_addr={addr[XLEN-1:2],2'b00}, dmem_be, dmem_we and dmem_wdata.
  - Set dmem_req=1 and go to REQ.
- Byte enables: B sets the single lane addr[1:0]; H sets 0011 or 1100 by addr[1]; W sets 1111.
- Store data: SB replicates mem_data[7:0] ×4; SH replicates mem_data[15:0] ×2; SW uses it unmodified.
- REQ state:
  - dmem_req and all dmem_* outputs stay stable until dmem_ack.
  - While dmem_ack=0, stall=1.
  - On the dmem_ack cycle: stall=0, dmem_req is cleared on the next edge, and the FSM returns to IDLE.
  - On that same edge, wb_params_out captures the result and EX/MEM advances.
- Load result: select the lane at offset addr[1:0] (held in a register from issue), then zero-extend for LBU/LHU or sign-extend for LB/LH.
- Store result: wb_params_out.rd_addr is forced to 0, which means no register write.
- Minimum load latency: op arrives at cycle 0 (stall), req at cycle 1, ack at cycle 1, wb valid at cycle 2.
- While stall=1, wb_params_out is driven to rd_addr=0. Bubbles therefore never write the register file twice.
- dmem_ack while in IDLE is ignored.
- dmem_rdata is sampled only on the ack cycle in REQ.

Decomposition:
- The types package gains:
  - mem_op_t enumerators MEM_OP_LB through MEM_OP_SW, alongside the existing MEM_OP_NONE.
  - wb_params_t with fields rd_addr and rd_data.
  - Helper functions mem_is_load and mem_is_store.
- One sub-module, load_align: purely combinational. Inputs are word, offset and mem_op; output is the extended XLEN result. It is reused later by the cache.

Test Plan:
- mem_op=NONE, rd_addr=3, rd_data=0x1234 -> stall never asserted; next cycle wb={3,0x1234}; dmem_req stays 0.
- LW at addr 0x100, rd_addr=5, ack after 2 wait cycles with rdata=0xDEADBEEF -> stall high 3 cycles; dmem_addr=0x100, be=1111 held stable; wb={5,0xDEADBEEF}.
- LB at 0x103 with rdata=0x80xxxxxx -> wb.rd_data=0xFFFFFF80. LBU on the same input -> 0x00000080.
- SH at 0x102 with mem_data=0xABCD, ack same cycle as req -> be=1100, wdata=0xABCDABCD, we=1; wb.rd_addr=0; stall high for exactly 1 cycle.
- LW at 0x101 -> no dmem_req; exc_misaligned pulses 1 cycle later; wb.rd_addr=0.
- Assert rst_n=0 while in REQ -> dmem_req=0 immediately; after release, state is IDLE, wb=0, and no spurious writeback occurs even if ack then arrives.
